// File: rtl/keypad_scan_fifo.sv
// 4x4 matrix keypad scanner with press/release debouncing and a small code FIFO
// that the bus decoder reads as a status word or as the head key code.
module keypad_scan_fifo #(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rowwrite,
  input  logic [3:0] colread,
  input  logic       ack,
  input  logic       statusordata,
  output logic [3:0] keyout
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {SCAN, DB_PRESS, PUSH, WAIT_REL} state_t;

  state_t        state;
  logic [1:0]    row_idx;
  logic [1:0]    next_row;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [3:0]    col_s1;
  logic [3:0]    col_s2;
  logic [3:0]    key_pat;
  logic [3:0]    key_latched;
  logic [1:0]    low_col;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          ack_d;
  logic          full;
  logic          not_empty;
  logic          pop;
  logic          push_req;
  logic          do_push;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_comb begin
    next_row = row_idx + 2'd1;
    low_col  = 2'd3;
    if (!col_s2[0])      low_col = 2'd0;
    else if (!col_s2[1]) low_col = 2'd1;
    else if (!col_s2[2]) low_col = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      row_idx     <= '0;
      rowwrite    <= 4'b1110;
      scan_cnt    <= '0;
      db_cnt      <= '0;
      col_s1      <= '1;
      col_s2      <= '1;
      key_pat     <= '1;
      key_latched <= '0;
    end else begin
      col_s1 <= colread;
      col_s2 <= col_s1;
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (col_s2 != 4'hF) begin
              key_pat     <= col_s2;
              key_latched <= key_code(row_idx, low_col);
              db_cnt      <= '0;
              state       <= DB_PRESS;
            end else begin
              row_idx  <= next_row;
              rowwrite <= ~(4'b0001 << next_row);
            end
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        DB_PRESS: begin
          if (col_s2 != key_pat) begin
            row_idx  <= next_row;
            rowwrite <= ~(4'b0001 << next_row);
            scan_cnt <= '0;
            state    <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            state <= PUSH;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        PUSH: begin
          db_cnt <= '0;
          state  <= WAIT_REL;
        end
        WAIT_REL: begin
          // any closed contact restarts the release window
          if (col_s2 != 4'hF) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            row_idx  <= next_row;
            rowwrite <= ~(4'b0001 << next_row);
            scan_cnt <= '0;
            state    <= SCAN;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  always_comb begin
    full      = (count == FULL_CNT);
    not_empty = (count != '0);
    pop       = ack & ~ack_d & not_empty;
    push_req  = (state == PUSH);
    // a pop in the same cycle frees the slot a full-FIFO push needs
    do_push   = push_req & (~full | pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ack_d    <= 1'b0;
    end else begin
      ack_d <= ack;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (pop)                   overflow <= 1'b0;
      else if (push_req && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= key_latched;
  end

  always_comb begin
    if (statusordata)   keyout = {overflow, full, 1'b0, not_empty};
    else if (not_empty) keyout = mem[rd_ptr];
    else                keyout = 4'h0;
  end

endmodule
